// File: rtl/sampler_pkg.sv
// Shared definitions for the IQ frame sampler: one-hot state encoding and channel packing.
package sampler_pkg;

    localparam int S_IDLE   = 0;
    localparam int S_READ   = 1;
    localparam int S_GAP    = 2;
    localparam int S_COMMIT = 3;
    localparam int STATE_W  = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = state_t'(1) << S_IDLE;
    localparam state_t ST_READ   = state_t'(1) << S_READ;
    localparam state_t ST_GAP    = state_t'(1) << S_GAP;
    localparam state_t ST_COMMIT = state_t'(1) << S_COMMIT;

    // LSB position of channel ch in a packed multi-channel word.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Programmable tick generator: one registered tick every (div+1) enabled clocks.
module rate_divider #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_value,
    input  logic             div_load,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= DIV_W'(DEFAULT_DIV);
            cnt_q <= DIV_W'(DEFAULT_DIV);
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            // A load restarts the period and swallows any tick due this cycle.
            if (div_load) begin
                div_q <= div_value;
                cnt_q <= div_value;
            end else if (!enable) begin
                cnt_q <= div_q;
            end else if (cnt_q == '0) begin
                cnt_q <= div_q;
                tick  <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/iq_frame_sampler.sv
// Pulls NUM_CH words per sample tick from a show-ahead FIFO and commits them as one frame.
module iq_frame_sampler
    import sampler_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 9999,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         div_value,
    input  logic                     div_load,
    input  logic                     underflow_mode,
    input  logic                     stat_clear,
    input  logic                     fifo_empty,
    input  logic [DATA_W-1:0]        fifo_data_out,
    output logic                     fifo_rd,
    output logic [NUM_CH*DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic                     busy,
    output logic [15:0]              underflow_cnt,
    output logic                     overrun
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     tick;
    state_t                   state_q;
    logic [CH_W-1:0]          ch_q;
    logic [1:0]               gap_q;
    logic [NUM_CH*DATA_W-1:0] staging_q;

    rate_divider #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .div_value(div_value),
        .div_load (div_load),
        .tick     (tick)
    );

    assign fifo_rd = state_q[S_READ] & ~fifo_empty;
    assign busy    = ~state_q[S_IDLE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ch_q          <= '0;
            gap_q         <= '0;
            staging_q     <= '0;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            underflow_cnt <= '0;
            overrun       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q <= ST_READ;
                        ch_q    <= '0;
                    end
                end
                ST_READ: begin
                    if (!fifo_empty) begin
                        staging_q[ch_lsb(int'(ch_q), DATA_W) +: DATA_W] <= fifo_data_out;
                    end else begin
                        // Empty slot: zero-fill or repeat the last committed word.
                        staging_q[ch_lsb(int'(ch_q), DATA_W) +: DATA_W] <= underflow_mode ?
                            sample_out[ch_lsb(int'(ch_q), DATA_W) +: DATA_W] : '0;
                        if (underflow_cnt != 16'hFFFF) begin
                            underflow_cnt <= underflow_cnt + 16'd1;
                        end
                    end
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_q <= ST_COMMIT;
                    end else if (GAP_CYCLES == 0) begin
                        ch_q <= ch_q + 1'b1;
                    end else begin
                        state_q <= ST_GAP;
                        gap_q   <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 2'(GAP_CYCLES - 1)) begin
                        state_q <= ST_READ;
                        ch_q    <= ch_q + 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    sample_out   <= staging_q;
                    sample_valid <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (tick && !state_q[S_IDLE]) begin
                overrun <= 1'b1;
            end
            // Clearing takes priority over a same-cycle increment or overrun.
            if (stat_clear) begin
                underflow_cnt <= '0;
                overrun       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iq_frame_sampler.sv
// Scoreboard bench: two sampler configurations fed by queue-backed show-ahead FIFO models.
module tb_iq_frame_sampler;

    logic        clk;
    logic        rst;
    logic        enable1, enable2;
    logic [15:0] div_value;
    logic        div_load, div_load2;
    logic        mode;
    logic        stat_clear;

    logic        fifo_empty1, fifo_empty2;
    logic [7:0]  fifo_data1;
    logic [11:0] fifo_data2;
    logic        fifo_rd1, fifo_rd2;
    logic [15:0] sample1;
    logic [47:0] sample2;
    logic        valid1, valid2, busy1, busy2, ovr1, ovr2;
    logic [15:0] ucnt1, ucnt2;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int rdcnt1 = 0;
    int viol = 0;
    logic prev_v1 = 1'b0;
    logic prev_v2 = 1'b0;

    logic [7:0]  fq1[$];
    logic [11:0] fq2[$];
    logic [15:0] exp1[$];
    logic [47:0] exp2[$];
    int vcyc[$];
    int v2cyc[$];
    int rd2cyc[$];

    iq_frame_sampler #(
        .DATA_W(8), .NUM_CH(2), .DIV_W(16), .DEFAULT_DIV(9), .GAP_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable1), .div_value(div_value), .div_load(div_load),
        .underflow_mode(mode), .stat_clear(stat_clear), .fifo_empty(fifo_empty1),
        .fifo_data_out(fifo_data1), .fifo_rd(fifo_rd1), .sample_out(sample1),
        .sample_valid(valid1), .busy(busy1), .underflow_cnt(ucnt1), .overrun(ovr1)
    );

    iq_frame_sampler #(
        .DATA_W(12), .NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(19), .GAP_CYCLES(0)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .div_value(div_value), .div_load(div_load2),
        .underflow_mode(mode), .stat_clear(stat_clear), .fifo_empty(fifo_empty2),
        .fifo_data_out(fifo_data2), .fifo_rd(fifo_rd2), .sample_out(sample2),
        .sample_valid(valid2), .busy(busy2), .underflow_cnt(ucnt2), .overrun(ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO models: pop on a sampled fifo_rd, head/empty refresh like a registered FIFO.
    always @(posedge clk) begin
        if (fifo_rd1) begin
            rdcnt1++;
            if (fifo_empty1) viol++;
            if (fq1.size() != 0) fq1.delete(0);
        end
        fifo_empty1 <= (fq1.size() == 0);
        fifo_data1  <= (fq1.size() != 0) ? fq1[0] : 8'h00;
        if (fifo_rd2) begin
            rd2cyc.push_back(cyc);
            if (fifo_empty2) viol++;
            if (fq2.size() != 0) fq2.delete(0);
        end
        fifo_empty2 <= (fq2.size() == 0);
        fifo_data2  <= (fq2.size() != 0) ? fq2[0] : 12'h000;
        cyc++;
    end

    // Monitor: every valid pulse pops and compares one expected frame.
    always @(negedge clk) begin
        if (valid1) begin
            vcyc.push_back(cyc);
            chk("valid1_width", 64'(prev_v1), 64'(0));
            if (exp1.size() == 0) chk("valid1_unexpected", 64'(1), 64'(0));
            else chk("sample1", 64'(sample1), 64'(exp1.pop_front()));
        end
        if (valid2) begin
            v2cyc.push_back(cyc);
            chk("valid2_width", 64'(prev_v2), 64'(0));
            if (exp2.size() == 0) chk("valid2_unexpected", 64'(1), 64'(0));
            else chk("sample2", 64'(sample2), 64'(exp2.pop_front()));
        end
        prev_v1 = valid1;
        prev_v2 = valid2;
    end

    task automatic wait_valids(input int n, input int budget, input string name);
        int k = 0;
        while (vcyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(vcyc.size() >= n), 64'(1));
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        while (!busy1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(busy1), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        int k;
        rst = 1'b1; enable1 = 1'b0; enable2 = 1'b0; div_value = '0; div_load = 1'b0;
        div_load2 = 1'b0; mode = 1'b0; stat_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sample_out", 64'(sample1), 64'(0));
        chk("rst_valid", 64'(valid1), 64'(0));
        chk("rst_busy", 64'(busy1), 64'(0));
        chk("rst_ucnt", 64'(ucnt1), 64'(0));
        chk("rst_overrun", 64'(ovr1), 64'(0));
        chk("rst_fifo_rd", 64'(fifo_rd1), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Normal frames: tick 10 clocks after enable, valid 5 clocks after tick.
        fq1.push_back(8'h11); fq1.push_back(8'h22); fq1.push_back(8'h33); fq1.push_back(8'h44);
        exp1.push_back(16'h2211); exp1.push_back(16'h4433);
        c0 = cyc;
        enable1 = 1'b1;
        wait_valids(2, 40, "p1_frames");
        enable1 = 1'b0;
        if (vcyc.size() >= 2) begin
            chk("p1_first_latency", 64'(vcyc[0] - c0), 64'(15));
            chk("p1_period", 64'(vcyc[1] - vcyc[0]), 64'(10));
        end
        repeat (4) @(negedge clk);
        chk("p1_rd_count", 64'(rdcnt1), 64'(4));
        chk("p1_idle", 64'(busy1), 64'(0));
        chk("p1_ucnt", 64'(ucnt1), 64'(0));
        chk("p1_overrun", 64'(ovr1), 64'(0));

        // Hold mode: ch1 repeats last committed 0x44.
        mode = 1'b1;
        fq1.push_back(8'h5A);
        exp1.push_back(16'h445A);
        enable1 = 1'b1;
        wait_valids(3, 40, "p2_frame");
        enable1 = 1'b0;
        @(negedge clk);
        chk("p2_ucnt", 64'(ucnt1), 64'(1));

        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        @(negedge clk);
        chk("p3_clear", 64'(ucnt1), 64'(0));

        // Zero mode, then three frames from an empty FIFO.
        mode = 1'b0;
        fq1.push_back(8'h5A);
        exp1.push_back(16'h005A);
        exp1.push_back(16'h0000); exp1.push_back(16'h0000); exp1.push_back(16'h0000);
        enable1 = 1'b1;
        wait_valids(7, 80, "p3_frames");
        enable1 = 1'b0;
        @(negedge clk);
        chk("p3_ucnt", 64'(ucnt1), 64'(7));
        chk("p3_sample_zero", 64'(sample1), 64'(0));
        if (vcyc.size() >= 7) chk("p3_period", 64'(vcyc[6] - vcyc[5]), 64'(10));

        // Period 3 is below the 5-clock minimum: the tick during ch1 READ overruns.
        div_value = 16'd2;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        exp1.push_back(16'h0000);
        enable1 = 1'b1;
        wait_busy("p4a_busy");
        repeat (2) @(negedge clk);
        enable1 = 1'b0;
        @(negedge clk);
        chk("p4a_overrun", 64'(ovr1), 64'(1));
        chk("p4a_ucnt", 64'(ucnt1), 64'(9));
        wait_valids(8, 20, "p4a_frame");

        // Clear lands together with an underflow and an overrun tick.
        repeat (3) @(negedge clk);
        exp1.push_back(16'h0000);
        enable1 = 1'b1;
        wait_busy("p4b_busy");
        repeat (2) @(negedge clk);
        stat_clear = 1'b1;
        enable1 = 1'b0;
        @(negedge clk);
        stat_clear = 1'b0;
        chk("p4b_ucnt_cleared", 64'(ucnt1), 64'(0));
        chk("p4b_overrun_cleared", 64'(ovr1), 64'(0));
        wait_valids(9, 20, "p4b_frame");

        // Commit a non-zero frame, then reset in the middle of the next one.
        fq1.push_back(8'h99); fq1.push_back(8'hAA);
        exp1.push_back(16'hAA99);
        enable1 = 1'b1;
        wait_busy("p5a_busy");
        repeat (2) @(negedge clk);
        enable1 = 1'b0;
        wait_valids(10, 20, "p5a_frame");
        fq1.push_back(8'h77); fq1.push_back(8'h88);
        enable1 = 1'b1;
        wait_busy("p5b_busy");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("p5_rst_sample", 64'(sample1), 64'(0));
        chk("p5_rst_busy", 64'(busy1), 64'(0));
        chk("p5_rst_fifo_rd", 64'(fifo_rd1), 64'(0));
        repeat (2) @(negedge clk);
        exp1.push_back(16'h0088);
        rst = 1'b0;
        n = 0;
        while (!busy1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        // Tick after DEFAULT_DIV+1 clocks, first READ one clock later.
        chk("p5_restart_latency", 64'(n), 64'(11));
        wait_valids(11, 20, "p5b_frame");
        enable1 = 1'b0;
        @(negedge clk);
        chk("p5_ucnt", 64'(ucnt1), 64'(1));
        chk("p5_rd_total", 64'(rdcnt1), 64'(10));
        chk("p5_fifo_drained", 64'(fq1.size()), 64'(0));

        // Four channels, no gap: back-to-back READs, valid five clocks after the first.
        fq2.push_back(12'h111); fq2.push_back(12'h222);
        fq2.push_back(12'h333); fq2.push_back(12'h444);
        exp2.push_back(48'h444_333_222_111);
        enable2 = 1'b1;
        k = 0;
        while (v2cyc.size() < 1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        enable2 = 1'b0;
        chk("p6_frame", 64'(v2cyc.size() >= 1), 64'(1));
        chk("p6_rd_count", 64'(rd2cyc.size()), 64'(4));
        if (rd2cyc.size() >= 4 && v2cyc.size() >= 1) begin
            for (int i = 1; i < 4; i++) begin
                chk($sformatf("p6_read%0d_cycle", i), 64'(rd2cyc[i] - rd2cyc[0]), 64'(i));
            end
            chk("p6_valid_latency", 64'(v2cyc[0] - rd2cyc[0]), 64'(5));
        end

        repeat (3) @(negedge clk);
        chk("rd_while_empty", 64'(viol), 64'(0));
        chk("exp1_drained", 64'(exp1.size()), 64'(0));
        chk("exp2_drained", 64'(exp2.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
